feature_mem_loader: RTL and testbench
=====================================

// Module: feature_mem_loader
// PURPOSE
//   Upstream fill stage for the input-feature memory of the systolic array.
//   Accepts a byte-serial feature stream (valid/ready) and packs N_ROWS_ARRAY lanes per word.
//   Writes each packed word to the feature memory write port at consecutive addresses.
//   Reports the last written address, which feeds the controller's end-of-feature compare.
// PARAMETERS
//   N_ROWS_ARRAY  16  lanes per memory word (one per array row)
//   I_WIDTH       8   bits per feature element
//   ADDR_WIDTH    16  feature memory address width
// PORTS
//   clk_i            in   1                     clock; all logic on rising edge
//   general_rst_n_i  in   1                     synchronous, active-low reset
//   start_i          in   1                     start a load (sampled in IDLE only)
//   base_addr_i      in   ADDR_WIDTH            first write address (sampled with start_i)
//   num_words_i      in   ADDR_WIDTH            max words to write (sampled with start_i)
//   s_data_i         in   I_WIDTH               stream element
//   s_valid_i        in   1                     stream element valid
//   s_last_i         in   1                     final element of stream (qualified by valid)
//   s_ready_o        out  1                     loader accepts element this cycle
//   wr_addrs_mem_o   out  ADDR_WIDTH            feature memory write address
//   mem_data_o       out  N_ROWS_ARRAY*I_WIDTH  packed word; lane k at [(k+1)*I_WIDTH-1 : k*I_WIDTH]
//   wr_mem_ld_o      out  1                     one-cycle write strobe
//   end_addr_o       out  ADDR_WIDTH            address of last word written by latest load
//   busy_o           out  1                     high outside IDLE
//   done_o           out  1                     one-cycle pulse when load finishes
//   early_last_o     out  1                     sticky: s_last_i seen before num_words_i reached
// BEHAVIOUR
//   Reset (general_rst_n_i=0 at clk edge): state IDLE; all outputs 0; pack register, lane/word counters 0.
//   FSM states: IDLE, PACK, WRITE, DONE.
//   IDLE: s_ready_o=0. start_i=1: latch base/num, clear counters, pack reg, early_last_o.
//     num_words_i!=0 -> PACK; num_words_i==0 -> DONE with no write, end_addr_o unchanged.
//   PACK: s_ready_o=1. Beat = s_valid_i & s_ready_o; store s_data_i in lane lane_cnt, lane_cnt++.
//     Transition to WRITE after beat when lane_cnt==N_ROWS_ARRAY-1 or s_last_i=1.
//     Partial word (last mid-word): unfilled lanes are 0.
//   WRITE: s_ready_o=0; wr_mem_ld_o=1 for exactly this cycle.
//     wr_addrs_mem_o = base + word_cnt (mod 2^ADDR_WIDTH, wraps silently); mem_data_o = pack reg.
//     end_addr_o <= wr_addrs_mem_o; word_cnt++; pack reg and lane_cnt cleared.
//     If word_cnt+1==num_words or last seen -> DONE, else -> PACK.
//   DONE: done_o=1 for one cycle; -> IDLE. early_last_o set here if last seen and word_cnt<num_words.
//   Latency: N_ROWS_ARRAY beats + 1 bubble per word; strobe the cycle after the word's final beat.
//   wr_addrs_mem_o/mem_data_o hold their values between strobes; only valid while wr_mem_ld_o=1.
//   Quota reached without s_last_i: load ends; further stream beats are not accepted (ready low).
//   start_i while busy_o=1: ignored. s_last_i without s_valid_i: ignored.
//   Reset mid-load: load aborts immediately, no further strobes, outputs return to reset values.
// TESTING
//   Full load: base=0x0010, num=2, 32 beats data=0..31, last on beat 31 -> strobes at 0x0010 (lanes 0..15), 0x0011 (16..31); end_addr_o=0x0011; done_o one pulse; early_last_o=0.
//   Partial word: num=4, 20 beats, last on beat 19 -> 2 strobes; second word lanes 0..3 = data 16..19, lanes 4..15 = 0; early_last_o=1.
//   Quota cut-off: num=1, 40 beats offered -> exactly one strobe, s_ready_o=0 after beat 16, done_o pulse.
//   Backpressure/gaps: random s_valid_i (50%) over 16 beats -> word identical to gapless case; strobe one cycle after 16th beat.
//   Wrap & edge: base=0xFFFF, num=2 -> strobes at 0xFFFF then 0x0000; num=0 -> done_o pulse, no strobe.
//   Reset mid-load after 7 beats -> no strobe; busy_o=0; next start loads correctly from lane 0.

Source files
------------

// File: rtl/feature_mem_loader_if.sv
// Stream-in and memory-write signals for feature_mem_loader.
// Stream handshake: a beat transfers on the rising edge where s_valid_i && s_ready_o; s_data_i/s_last_i are qualified by s_valid_i.
interface feature_mem_loader_if #(
  parameter int N_ROWS_ARRAY = 16,
  parameter int I_WIDTH      = 8,
  parameter int ADDR_WIDTH   = 16
);
  logic [I_WIDTH-1:0]              s_data_i;
  logic                            s_valid_i;
  logic                            s_last_i;
  logic                            s_ready_o;
  logic [ADDR_WIDTH-1:0]           wr_addrs_mem_o;
  logic [N_ROWS_ARRAY*I_WIDTH-1:0] mem_data_o;
  logic                            wr_mem_ld_o;

  modport slave (
    input  s_data_i, s_valid_i, s_last_i,
    output s_ready_o, wr_addrs_mem_o, mem_data_o, wr_mem_ld_o
  );

  modport master (
    output s_data_i, s_valid_i, s_last_i,
    input  s_ready_o, wr_addrs_mem_o, mem_data_o, wr_mem_ld_o
  );
endinterface

// File: rtl/feature_mem_loader.sv
// Packs a byte-serial feature stream into N_ROWS_ARRAY-lane words and writes them
// to consecutive feature-memory addresses, reporting the last address written.
module feature_mem_loader #(
  parameter int N_ROWS_ARRAY = 16,
  parameter int I_WIDTH      = 8,
  parameter int ADDR_WIDTH   = 16
) (
  input  logic                  clk_i,
  input  logic                  general_rst_n_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [ADDR_WIDTH-1:0] num_words_i,
  feature_mem_loader_if.slave   bus,
  output logic [ADDR_WIDTH-1:0] end_addr_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  early_last_o,
  output logic [1:0]            state_o
);
  localparam int DATA_W = N_ROWS_ARRAY * I_WIDTH;
  localparam int LANE_W = (N_ROWS_ARRAY > 1) ? $clog2(N_ROWS_ARRAY) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PACK  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [LANE_W-1:0]     lane_cnt_q, lane_cnt_d;
  logic [ADDR_WIDTH-1:0] word_cnt_q, word_cnt_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH-1:0] num_q, num_d;
  logic [DATA_W-1:0]     pack_q, pack_d;
  logic                  last_seen_q, last_seen_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_W-1:0]     data_q, data_d;
  logic [ADDR_WIDTH-1:0] end_addr_q, end_addr_d;
  logic                  early_last_q, early_last_d;

  always_comb begin
    state_d      = state_q;
    lane_cnt_d   = lane_cnt_q;
    word_cnt_d   = word_cnt_q;
    base_d       = base_q;
    num_d        = num_q;
    pack_d       = pack_q;
    last_seen_d  = last_seen_q;
    addr_d       = addr_q;
    data_d       = data_q;
    end_addr_d   = end_addr_q;
    early_last_d = early_last_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          base_d       = base_addr_i;
          num_d        = num_words_i;
          word_cnt_d   = '0;
          lane_cnt_d   = '0;
          pack_d       = '0;
          last_seen_d  = 1'b0;
          early_last_d = 1'b0;
          state_d      = (num_words_i == '0) ? ST_DONE : ST_PACK;
        end
      end
      ST_PACK: begin
        if (bus.s_valid_i) begin
          for (int k = 0; k < N_ROWS_ARRAY; k++) begin
            if (lane_cnt_q == LANE_W'(k)) pack_d[k*I_WIDTH +: I_WIDTH] = bus.s_data_i;
          end
          lane_cnt_d = lane_cnt_q + 1'b1;
          if (bus.s_last_i) last_seen_d = 1'b1;
          // Capture the finished word here so the write outputs hold it until the next strobe.
          if (lane_cnt_q == LANE_W'(N_ROWS_ARRAY - 1) || bus.s_last_i) begin
            state_d = ST_WRITE;
            addr_d  = base_q + word_cnt_q;
            data_d  = pack_d;
          end
        end
      end
      ST_WRITE: begin
        end_addr_d = addr_q;
        word_cnt_d = word_cnt_q + 1'b1;
        pack_d     = '0;
        lane_cnt_d = '0;
        state_d    = ((word_cnt_q + 1'b1) == num_q || last_seen_q) ? ST_DONE : ST_PACK;
      end
      default: begin
        if (last_seen_q && (word_cnt_q < num_q)) early_last_d = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!general_rst_n_i) begin
      state_q      <= ST_IDLE;
      lane_cnt_q   <= '0;
      word_cnt_q   <= '0;
      base_q       <= '0;
      num_q        <= '0;
      pack_q       <= '0;
      last_seen_q  <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      end_addr_q   <= '0;
      early_last_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      lane_cnt_q   <= lane_cnt_d;
      word_cnt_q   <= word_cnt_d;
      base_q       <= base_d;
      num_q        <= num_d;
      pack_q       <= pack_d;
      last_seen_q  <= last_seen_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      end_addr_q   <= end_addr_d;
      early_last_q <= early_last_d;
    end
  end

  assign bus.s_ready_o      = (state_q == ST_PACK);
  assign bus.wr_mem_ld_o    = (state_q == ST_WRITE);
  assign bus.wr_addrs_mem_o = addr_q;
  assign bus.mem_data_o     = data_q;
  assign end_addr_o         = end_addr_q;
  assign busy_o             = (state_q != ST_IDLE);
  assign done_o             = (state_q == ST_DONE);
  assign early_last_o       = early_last_q;
  assign state_o            = state_q;
endmodule

// File: tb/tb_feature_mem_loader.sv
// Randomized scoreboard bench for feature_mem_loader: a list-based model predicts
// every memory write, and a monitor checks each strobe as it appears.
module tb_feature_mem_loader;
  localparam int N  = 16;
  localparam int IW = 8;
  localparam int AW = 16;
  localparam int DW = N * IW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW-1:0] num_words;
  logic [AW-1:0] end_addr;
  logic          busy, done, early_last;
  logic [1:0]    state;

  feature_mem_loader_if #(.N_ROWS_ARRAY(N), .I_WIDTH(IW), .ADDR_WIDTH(AW)) bus ();

  feature_mem_loader #(.N_ROWS_ARRAY(N), .I_WIDTH(IW), .ADDR_WIDTH(AW)) dut (
    .clk_i(clk), .general_rst_n_i(rst_n), .start_i(start),
    .base_addr_i(base_addr), .num_words_i(num_words), .bus(bus),
    .end_addr_o(end_addr), .busy_o(busy), .done_o(done),
    .early_last_o(early_last), .state_o(state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] exp_q[$];
  logic [AW-1:0] exp_addr_q[$];

  logic [IW-1:0] stim[0:79];
  int            n_beats;
  int            last_idx;
  int            exp_beats;
  logic [AW-1:0] exp_end = '0;
  logic          exp_early;
  int            done_cnt;
  int            cyc = 0;
  int            last_beat_cyc = -10;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every strobe and checks the write latency.
  always @(negedge clk) begin
    cyc++;
    if (done) done_cnt++;
    if (bus.wr_mem_ld_o) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_strobe", 1, 0);
      end else begin
        chk("strobe_addr", DW'(bus.wr_addrs_mem_o), DW'(exp_addr_q.pop_front()));
        chk("strobe_data", bus.mem_data_o, exp_q.pop_front());
        chk("strobe_latency", DW'(cyc), DW'(last_beat_cyc + 1));
      end
    end
    if (bus.s_valid_i && bus.s_ready_o) last_beat_cyc = cyc;
  end

  // Reference: walk the element list word by word until quota or last.
  task automatic build_expect(input logic [AW-1:0] base, input logic [AW-1:0] num);
    int p = 0;
    int words = 0;
    bit last_hit = 0;
    logic [DW-1:0] word;
    while (words < int'(num) && !last_hit) begin
      word = '0;
      for (int l = 0; l < N; l++) begin
        if (p >= n_beats) break;
        word[l*IW +: IW] = stim[p];
        if (p == last_idx) last_hit = 1;
        p++;
        if (last_hit) break;
      end
      exp_addr_q.push_back(AW'(int'(base) + words));
      exp_q.push_back(word);
      words++;
    end
    exp_beats = p;
    if (words > 0) exp_end = AW'(int'(base) + words - 1);
    exp_early = last_hit && (words < int'(num));
  endtask

  task automatic do_start(input logic [AW-1:0] b, input logic [AW-1:0] n);
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; num_words = n;
    @(posedge clk); #1;
    start = 1'b0; base_addr = $urandom; num_words = $urandom;
  endtask

  // Drives the stream until the loader returns to idle, then checks the load summary.
  task automatic run_load(input string name, input logic [AW-1:0] b, input logic [AW-1:0] n,
                          input int vpct, input bit start_noise);
    int i = 0;
    int budget = 0;
    bit acc;
    build_expect(b, n);
    done_cnt = 0;
    do_start(b, n);
    while (busy && budget < 2000) begin
      if (i < n_beats) begin
        bus.s_valid_i = ($urandom_range(0, 99) < vpct);
        bus.s_data_i  = stim[i];
        bus.s_last_i  = (i == last_idx);
      end else begin
        bus.s_valid_i = 1'b0;
        bus.s_data_i  = $urandom;
        bus.s_last_i  = $urandom;
      end
      start = start_noise && (i < 8) && $urandom_range(0, 1) == 1;
      @(negedge clk);
      acc = bus.s_valid_i && bus.s_ready_o;
      @(posedge clk); #1;
      if (acc) i++;
      budget++;
    end
    start = 1'b0;
    bus.s_valid_i = 1'b0;
    chk({name, "_timeout"}, DW'(budget >= 2000), 0);
    repeat (2) @(posedge clk);
    #1;
    chk({name, "_beats"}, DW'(i), DW'(exp_beats));
    chk({name, "_done_pulses"}, DW'(done_cnt), 1);
    chk({name, "_end_addr"}, DW'(end_addr), DW'(exp_end));
    chk({name, "_early_last"}, DW'(early_last), DW'(exp_early));
    chk({name, "_ready_idle"}, DW'(bus.s_ready_o), 0);
    chk({name, "_all_strobes"}, DW'(exp_q.size()), 0);
  endtask

  task automatic fill_seq(input int nb, input int li);
    n_beats = nb; last_idx = li;
    for (int k = 0; k < 80; k++) stim[k] = IW'(k);
  endtask

  task automatic fill_rand(input int nb, input int li);
    n_beats = nb; last_idx = li;
    for (int k = 0; k < 80; k++) stim[k] = IW'($urandom);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; base_addr = '0; num_words = '0;
    bus.s_valid_i = 1'b0; bus.s_data_i = '0; bus.s_last_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", DW'(busy), 0);
    chk("rst_done", DW'(done), 0);
    chk("rst_ready", DW'(bus.s_ready_o), 0);
    chk("rst_strobe", DW'(bus.wr_mem_ld_o), 0);
    chk("rst_addr", DW'(bus.wr_addrs_mem_o), 0);
    chk("rst_data", bus.mem_data_o, 0);
    chk("rst_end_addr", DW'(end_addr), 0);
    chk("rst_early", DW'(early_last), 0);
    rst_n = 1'b1;

    fill_seq(32, 31);       run_load("full", 16'h0010, 16'd2, 100, 0);
    fill_seq(20, 19);       run_load("partial", 16'h0100, 16'd4, 100, 0);
    fill_seq(40, -1);       run_load("quota", 16'h0200, 16'd1, 100, 0);
    fill_rand(16, 15);      run_load("gaps", 16'h0300, 16'd1, 50, 1);
    fill_rand(32, -1);      run_load("wrap", 16'hFFFF, 16'd2, 70, 0);
    fill_rand(0, -1);       run_load("num_zero", 16'h0400, 16'd0, 100, 0);

    // Abort after seven beats: no strobe may follow and the next load starts clean.
    fill_seq(32, 31);
    do_start(16'h0500, 16'd2);
    for (int k = 0; k < 7; k++) begin
      bus.s_valid_i = 1'b1; bus.s_data_i = stim[k]; bus.s_last_i = 1'b0;
      @(posedge clk); #1;
    end
    bus.s_valid_i = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_end = '0;
    chk("abort_busy", DW'(busy), 0);
    chk("abort_end_addr", DW'(end_addr), 0);
    chk("abort_strobe", DW'(bus.wr_mem_ld_o), 0);
    repeat (3) @(posedge clk);
    fill_rand(16, 15);      run_load("after_abort", 16'h0600, 16'd1, 100, 0);

    for (int t = 0; t < 6; t++) begin
      int nw = $urandom_range(1, 3);
      if ($urandom_range(0, 1) == 1) begin
        int nb = $urandom_range(1, 50);
        fill_rand(nb, nb - 1);
      end else begin
        fill_rand(nw * N + $urandom_range(0, 5), -1);
      end
      run_load("random", AW'($urandom), AW'(nw), $urandom_range(40, 100), 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
